// File: rtl/spe_arb_pkg.sv
// Shared types and constants for the SPE output arbiter.
// Optional statistics counters are enabled by defining SPE_ARB_STATS_EN.
package spe_arb_pkg;

    localparam int PKT_W    = 32;

    // Packet field positions (informational; the arbiter never decodes fields)
    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 28;
    localparam int OPC_MSB  = 27;
    localparam int OPC_LSB  = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 0;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/spe_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ.
module spe_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] win
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Scan requesters in priority order starting at ptr; the first hit wins
    always_comb begin
        any  = 1'b0;
        win  = '0;
        sum  = '0;
        cand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            cand = sum[PW-1:0];
            if (!any && req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

endmodule

// File: rtl/spe_out_arbiter.sv
// Round-robin arbiter sharing one NoC injection port among N_REQ SPE
// packetizers, with a single registered output slot.
// Optional per-requester saturating transfer counters: SPE_ARB_STATS_EN.
module spe_out_arbiter #(
    parameter int N_REQ = 4,
    parameter int PKT_W = spe_arb_pkg::PKT_W
`ifdef SPE_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*PKT_W-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] out_src
`ifdef SPE_ARB_STATS_EN
    ,
    input  logic [$clog2(N_REQ)-1:0] stat_sel,
    input  logic                     stat_clr,
    output logic [CNT_W-1:0]         stat_count
`endif
);

    import spe_arb_pkg::*;

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PKT_W-1:0] out_data_q, out_data_d;
    logic [PTR_W-1:0] out_src_q, out_src_d;

    logic             pick_any;
    logic [PTR_W-1:0] pick_win;
    logic             load_ok;
    logic             grant;
    logic [PKT_W-1:0] win_data;

    spe_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

    // Grant decision, winner data mux and next-state for the output slot
    always_comb begin
        load_ok   = (state_q == ARB_EMPTY) || out_ready;
        // req_ready must stay low during an asynchronous reset
        grant     = !rst && load_ok && pick_any;

        req_ready = '0;
        if (grant) begin
            req_ready[pick_win] = 1'b1;
        end

        win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_win == PTR_W'(i)) begin
                win_data = req_data[i*PKT_W +: PKT_W];
            end
        end

        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;

        if (grant) begin
            state_d    = ARB_FULL;
            out_data_d = win_data;
            out_src_d  = pick_win;
            ptr_d      = (pick_win == PTR_W'(N_REQ-1)) ? '0 : pick_win + 1'b1;
        end else if (state_q == ARB_FULL && out_ready) begin
            state_d = ARB_EMPTY;
        end
    end

    // Slot, source and priority pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_EMPTY;
            ptr_q      <= '0;
            out_data_q <= '0;
            out_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
        end
    end

    assign out_valid = (state_q == ARB_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef SPE_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    // Saturating per-requester transfer counters; clear beats increment
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr) begin
                cnt_d[i] = '0;
            end else if (grant && pick_win == PTR_W'(i) && cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Combinational counter read
    always_comb begin
        stat_count = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (stat_sel == PTR_W'(i)) begin
                stat_count = cnt_q[i];
            end
        end
    end
`endif

endmodule
